// File: rtl/i2c_reg_seq.sv
// Single-register I2C read/write sequencer driving a byte-level i2c_master core.
// Walks a fixed command list per access, handles address/data NAK with optional retries.
module i2c_reg_seq #(
  parameter int unsigned RETRIES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic       rsp_nak,
  output logic [7:0] rsp_rdata,
  output logic [1:0] i2c_cmd,
  output logic       i2c_stb,
  output logic [7:0] i2c_data_in,
  output logic       i2c_ack_in,
  input  logic [7:0] i2c_data_out,
  input  logic       i2c_ack_out,
  input  logic       i2c_ready
);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;
  localparam logic [2:0] MAX_RETRY = 3'(RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t     state;
  logic [2:0] step;
  logic [2:0] retry_cnt;
  logic       nak_flag;
  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;

  logic [1:0] step_cmd;
  logic [7:0] step_data;
  logic [2:0] stop_step;

  // Command list lookup for the current step of a write or read access
  always_comb begin
    step_cmd  = CMD_STOP;
    step_data = 8'h00;
    stop_step = rw_q ? 3'd6 : 3'd4;
    case (step)
      3'd0: step_cmd = CMD_START;
      3'd1: begin step_cmd = CMD_WRITE; step_data = {dev_q, 1'b0}; end
      3'd2: begin step_cmd = CMD_WRITE; step_data = reg_q; end
      3'd3: begin
        if (rw_q) step_cmd = CMD_START;
        else begin step_cmd = CMD_WRITE; step_data = wdata_q; end
      end
      3'd4: if (rw_q) begin step_cmd = CMD_WRITE; step_data = {dev_q, 1'b1}; end
      3'd5: if (rw_q) step_cmd = CMD_READ;
      default: step_cmd = CMD_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      step        <= 3'd0;
      retry_cnt   <= 3'd0;
      nak_flag    <= 1'b0;
      rw_q        <= 1'b0;
      dev_q       <= 7'h00;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_nak     <= 1'b0;
      rsp_rdata   <= 8'h00;
      i2c_cmd     <= CMD_START;
      i2c_stb     <= 1'b0;
      i2c_data_in <= 8'h00;
      i2c_ack_in  <= 1'b0;
    end else begin
      i2c_stb   <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            rw_q      <= req_rw;
            dev_q     <= req_dev;
            reg_q     <= req_reg;
            wdata_q   <= req_wdata;
            rdata_q   <= 8'h00;
            step      <= 3'd0;
            retry_cnt <= 3'd0;
            nak_flag  <= 1'b0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i2c_ready) begin
            i2c_stb     <= 1'b1;
            i2c_cmd     <= step_cmd;
            i2c_data_in <= step_data;
            i2c_ack_in  <= (step_cmd == CMD_READ);
            state       <= S_SETTLE;
          end
        end
        // Core needs a cycle to drop ready after the strobe
        S_SETTLE: state <= S_WAIT;
        S_WAIT:   if (i2c_ready) state <= S_CHECK;
        S_CHECK: begin
          if (i2c_cmd == CMD_WRITE && i2c_ack_out) begin
            nak_flag <= 1'b1;
            step     <= stop_step;
            state    <= S_ISSUE;
          end else if (i2c_cmd == CMD_STOP) begin
            state <= S_DONE;
          end else begin
            if (i2c_cmd == CMD_READ) rdata_q <= i2c_data_out;
            step  <= step + 3'd1;
            state <= S_ISSUE;
          end
        end
        S_DONE: begin
          if (nak_flag && retry_cnt < MAX_RETRY) begin
            retry_cnt <= retry_cnt + 3'd1;
            nak_flag  <= 1'b0;
            step      <= 3'd0;
            state     <= S_ISSUE;
          end else begin
            rsp_valid <= 1'b1;
            rsp_nak   <= nak_flag;
            rsp_rdata <= (rw_q && !nak_flag) ? rdata_q : 8'h00;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Randomized and directed bench for i2c_reg_seq against a list-level model of
// the expected command stream and a behavioural i2c_master core.
module tb_i2c_reg_seq;

  localparam int unsigned RETRIES_TB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev = 7'h00;
  logic [7:0] req_reg = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_nak;
  logic [7:0] rsp_rdata;
  logic [1:0] i2c_cmd;
  logic       i2c_stb;
  logic [7:0] i2c_data_in;
  logic       i2c_ack_in;
  logic [7:0] i2c_data_out = 8'h00;
  logic       i2c_ack_out = 1'b0;
  logic       i2c_ready = 1'b1;

  int nvec = 0;
  int nerr = 0;

  // core model controls
  logic [7:0]  c_rbyte = 8'h00;
  int          c_naks = 0;
  int          c_delay = 1;
  int          busy = 0;
  logic        prev_stb = 1'b0;
  logic [1:0]  prev_cmd = 2'b01;
  logic        have_last = 1'b0;
  logic [10:0] last_out = '0;
  logic [10:0] log_q[$];

  i2c_reg_seq #(.RETRIES(RETRIES_TB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_nak(rsp_nak), .rsp_rdata(rsp_rdata),
    .i2c_cmd(i2c_cmd), .i2c_stb(i2c_stb), .i2c_data_in(i2c_data_in),
    .i2c_ack_in(i2c_ack_in), .i2c_data_out(i2c_data_out),
    .i2c_ack_out(i2c_ack_out), .i2c_ready(i2c_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural core: logs strobes, goes busy for c_delay cycles, NAKs address bytes on request
  always @(negedge clk) begin
    if (rst) begin
      i2c_ready = 1'b1;
      busy      = 0;
      have_last = 1'b0;
      prev_stb  = 1'b0;
      prev_cmd  = 2'b01;
    end else begin
      if (i2c_stb) begin
        chk("stb_while_not_ready", 32'(i2c_ready), 32'd1);
        chk("stb_back_to_back", 32'(prev_stb), 32'd0);
        log_q.push_back({i2c_cmd, i2c_data_in, i2c_ack_in});
        last_out  = {i2c_cmd, i2c_data_in, i2c_ack_in};
        have_last = 1'b1;
        i2c_ack_out = 1'b0;
        if (i2c_cmd == 2'b10 && prev_cmd == 2'b00 && !i2c_data_in[0] && c_naks > 0) begin
          i2c_ack_out = 1'b1;
          c_naks--;
        end
        if (i2c_cmd == 2'b11) i2c_data_out = c_rbyte;
        prev_cmd  = i2c_cmd;
        i2c_ready = 1'b0;
        busy      = c_delay;
      end else begin
        if (have_last) chk("cmd_stable", 32'({i2c_cmd, i2c_data_in, i2c_ack_in}), 32'(last_out));
        if (busy > 0) begin
          busy--;
          if (busy == 0) i2c_ready = 1'b1;
        end
      end
      prev_stb = i2c_stb;
    end
  end

  function automatic logic [10:0] ent(input logic [1:0] c, input logic [7:0] d);
    return {c, d, (c == 2'b11)};
  endfunction

  task automatic run_txn(input string tag, input logic rw, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd, input logic [7:0] rb,
                         input int naks, input int dly);
    logic [10:0] exp_q[$];
    logic        exp_nak;
    logic [7:0]  exp_rdata;
    int          attempts;
    logic        got;
    int          n;
    exp_nak   = (naks > int'(RETRIES_TB));
    attempts  = exp_nak ? int'(RETRIES_TB) + 1 : naks + 1;
    exp_rdata = (rw && !exp_nak) ? rb : 8'h00;
    for (int a = 0; a < attempts; a++) begin
      exp_q.push_back(ent(2'b00, 8'h00));
      exp_q.push_back(ent(2'b10, {dev, 1'b0}));
      if (a < naks) begin
        exp_q.push_back(ent(2'b01, 8'h00));
      end else begin
        exp_q.push_back(ent(2'b10, rg));
        if (rw) begin
          exp_q.push_back(ent(2'b00, 8'h00));
          exp_q.push_back(ent(2'b10, {dev, 1'b1}));
          exp_q.push_back(ent(2'b11, 8'h00));
        end else begin
          exp_q.push_back(ent(2'b10, wd));
        end
        exp_q.push_back(ent(2'b01, 8'h00));
      end
    end
    c_rbyte = rb; c_naks = naks; c_delay = dly;
    log_q.delete();
    @(posedge clk); #1;
    req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
    end
    chk({tag, "_accept"}, 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!got) return;
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
    if (!got) return;
    chk({tag, "_rsp_nak"}, 32'(rsp_nak), 32'(exp_nak));
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
    @(negedge clk);
    chk({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_n_strobes"}, 32'(log_q.size()), 32'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_cmd%0d", tag, i), 32'(log_q[i][10:9]), 32'(exp_q[i][10:9]));
      if (exp_q[i][10:9] == 2'b10)
        chk($sformatf("%s_data%0d", tag, i), 32'(log_q[i][8:1]), 32'(exp_q[i][8:1]));
      if (exp_q[i][10:9] == 2'b11)
        chk($sformatf("%s_ack%0d", tag, i), 32'(log_q[i][0]), 32'd1);
    end
  endtask

  initial begin
    logic got;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_nak", 32'(rsp_nak), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_stb", 32'(i2c_stb), 32'd0);
    chk("rst_cmd", 32'(i2c_cmd), 32'd0);
    chk("rst_data_in", 32'(i2c_data_in), 32'd0);
    chk("rst_ack_in", 32'(i2c_ack_in), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_txn("wr_basic", 1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 0, 2);
    run_txn("rd_basic", 1'b1, 7'h50, 8'h07, 8'h00, 8'h3C, 0, 3);
    run_txn("wr_nak_all", 1'b0, 7'h50, 8'h12, 8'h5A, 8'h00, 3, 1);
    run_txn("rd_nak_all", 1'b1, 7'h21, 8'h33, 8'h00, 8'hEE, 3, 2);
    run_txn("wr_retry_ok", 1'b0, 7'h50, 8'h44, 8'h99, 8'h00, 2, 1);
    run_txn("rd_retry1", 1'b1, 7'h68, 8'h0F, 8'h00, 8'hC3, 1, 2);
    run_txn("rd_slow", 1'b1, 7'h50, 8'h07, 8'h00, 8'h3C, 0, 20);

    // Reset while waiting on the register byte
    c_naks = 0; c_delay = 10; c_rbyte = 8'h00;
    log_q.delete();
    @(posedge clk); #1;
    req_rw = 1'b0; req_dev = 7'h50; req_reg = 8'h12; req_wdata = 8'hA5; req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (req_ready) begin @(posedge clk); #1; req_valid = 1'b0; end
      if (log_q.size() >= 3) got = 1'b1;
    end
    req_valid = 1'b0;
    chk("mid_rst_reached_reg_byte", 32'(got), 32'd1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_stb", 32'(i2c_stb), 32'd0);
    chk("mid_rst_req_ready0", 32'(req_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("mid_rst_req_ready1", 32'(req_ready), 32'd1);
    run_txn("post_rst_wr", 1'b0, 7'h2A, 8'h80, 8'h3C, 8'h00, 0, 2);

    for (int k = 0; k < 8; k++) begin
      run_txn($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), 7'($urandom),
              8'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(1, 6)));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/i2c_reg_seq.md
Name: i2c_reg_seq

Overview:
Register-access sequencer in front of the byte-level i2c_master core.
- Accepts one 8-bit-register read or write request at a time.
- Issues the full START/address/register/data/STOP command sequence to the core over its cmd/stb/ready interface.
- Returns read data and a NAK status.
- Lets firmware or other logic do single-register I2C accesses without stepping the core byte by byte.

Parameters:
RETRIES, 0, number of additional full-transaction attempts after a NAK (0..7).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready
req_rw  in  1  1 = read, 0 = write
req_dev  in  7  7-bit device address
req_reg  in  8  register index
req_wdata  in  8  write data (ignored for reads)
rsp_valid  out  1  one-cycle pulse: transaction finished
rsp_nak  out  1  valid with rsp_valid: final attempt saw NAK
rsp_rdata  out  8  valid with rsp_valid: read byte (0x00 for writes or NAK)
i2c_cmd  out  2  core command: 00 START, 01 STOP, 10 WRITE, 11 READ
i2c_stb  out  1  one-cycle command strobe to core
i2c_data_in  out  8  byte for WRITE
i2c_ack_in  out  1  ack bit driven on READ (1 = NAK)
i2c_data_out  in  8  byte from READ
i2c_ack_out  in  1  ack sampled on WRITE (1 = NAK)
i2c_ready  in  1  core idle / previous command complete

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: req_ready=0, rsp_valid=0, rsp_nak=0, rsp_rdata=0x00, i2c_stb=0, i2c_cmd=00, i2c_data_in=0x00, i2c_ack_in=0. State = IDLE, step=0, retry count=0.
- req_ready:
  - =1 only in IDLE, registered.
  - The acceptance cycle latches rw/dev/reg/wdata into internal registers and moves to ISSUE.
  - req_ready drops the next cycle.
- Step lists (step counter indexes the list):
  - Write: START; WRITE {dev,0}; WRITE reg; WRITE wdata; STOP.
  - Read: START; WRITE {dev,0}; WRITE reg; START (repeated); WRITE {dev,1}; READ with ack_in=1; STOP.
- FSM states: IDLE, ISSUE, SETTLE, WAIT, CHECK, DONE.
  - ISSUE: waits for i2c_ready=1, then drives cmd/data_in/ack_in for the current step with i2c_stb=1 for exactly one cycle, and goes to SETTLE.
  - SETTLE: one dead cycle so ready is not sampled before the core has dropped it. Always goes to WAIT.
  - WAIT: holds until i2c_ready=1, then goes to CHECK.
  - CHECK:
    - After a WRITE with i2c_ack_out=1: NAK flag set; step jumps to the STOP step; go to ISSUE.
    - After READ: capture i2c_data_out into the read register.
    - After STOP: go to DONE.
    - Otherwise: step+1, go to ISSUE.
  - DONE:
    - If the NAK flag is set and retry count < RETRIES: retry count+1, clear the NAK flag, step=0, go to ISSUE.
    - Otherwise: rsp_valid=1 for one cycle with rsp_nak=NAK flag and rsp_rdata = read register (0x00 if write or NAK). Go to IDLE.
- Strobe rules:
  - i2c_stb is never asserted while i2c_ready=0.
  - i2c_stb is never asserted on two consecutive cycles.
  - cmd/data_in/ack_in stay stable from the strobe cycle until the next strobe.
- STOP is always issued once START was issued, including after a NAK.
- Latency, write with no NAK: 5 commands. Each command costs 1 ISSUE + 1 SETTLE + core time + 1 CHECK cycle. rsp_valid arrives 1 cycle after the final CHECK.
- req_valid during a busy transaction is ignored; the requester holds it until req_ready.
- Reset mid-transaction: all outputs return to reset values next cycle and no STOP is generated. Bus recovery is the core/system's concern.
- Retry counter is 3 bits and is cleared on each accepted request.

Test Plan:
- Write dev=0x50 reg=0x12 data=0xA5, core model ACKs all bytes.
  - Strobes carry cmds START, WRITE 0xA0, WRITE 0x12, WRITE 0xA5, STOP in that order.
  - One rsp_valid with rsp_nak=0.
- Read dev=0x50 reg=0x07, core returns 0x3C.
  - Strobes: START, WRITE 0xA0, WRITE 0x07, START, WRITE 0xA1, READ (ack_in=1), STOP.
  - rsp_rdata=0x3C, rsp_nak=0.
- Address NAK with RETRIES=0: ack_out=1 on WRITE 0xA0 → next strobe is STOP; rsp_nak=1, rsp_rdata=0x00.
- RETRIES=2, NAK on the first two attempts, ACK on the third → 3 START strobes and 3 STOP strobes in total; rsp_nak=0.
- Core holds ready low for 20 cycles after each strobe → no strobe while ready=0, no back-to-back strobes; the command sequence is unchanged.
- rst pulsed during the WAIT of the register byte → next cycle i2c_stb=0 and req_ready=0; the cycle after, req_ready=1. A new request then completes normally.
